// File: rtl/spi_miso_tri_ctrl.sv
// Multi-channel SPI-slave MISO tristate control: one shared transmit shifter, one-hot pad enable.
// Optional pad readback check is enabled with the MISO_READBACK_CHECK_EN macro.
module spi_miso_tri_ctrl #(
  parameter int               NUM_CH = 4,
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] FILL   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ss_n,
  input  logic              sclk,
  input  logic [WIDTH-1:0]  tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [NUM_CH-1:0] miso_d,
  output logic [NUM_CH-1:0] miso_oe,
  output logic              word_done,
  output logic              underrun,
  output logic              conflict,
  input  logic              miso_in,
  output logic              miso_probe
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CONFLICT} state_t;

  logic [NUM_CH-1:0] ss_s1, ss_s2;
  logic              sclk_s1, sclk_s2, sclk_s3;
  logic              sclk_rise, sclk_fall;
  state_t            state, state_nx;
  logic [IW-1:0]     ch_idx, ch_nx, low_idx;
  logic [WIDTH-1:0]  shreg, sh_nx, hold_data;
  logic              hold_valid;
  logic [CW-1:0]     bit_cnt, cnt_nx;
  logic              done_nx, under_nx, take;
  logic [4:0]        low_cnt;
  logic [NUM_CH-1:0] sel_mask;
  logic              other_low;

  // Selects resync to "deselected" so reset never looks like a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_s1   <= '1;
      ss_s2   <= '1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
    end else begin
      ss_s1   <= ss_n;
      ss_s2   <= ss_s1;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;

  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!ss_s2[i]) begin
        low_cnt = low_cnt + 5'd1;
        low_idx = IW'(i);
      end
    end
  end

  assign sel_mask  = NUM_CH'(1) << ch_idx;
  assign other_low = |(~ss_s2 & ~sel_mask);

  always_comb begin
    state_nx = state;
    ch_nx    = ch_idx;
    sh_nx    = shreg;
    cnt_nx   = bit_cnt;
    done_nx  = 1'b0;
    under_nx = 1'b0;
    take     = 1'b0;
    case (state)
      IDLE: begin
        if (low_cnt > 5'd1) begin
          state_nx = CONFLICT;
        end else if (low_cnt == 5'd1) begin
          take     = 1'b1;
          ch_nx    = low_idx;
          sh_nx    = hold_valid ? hold_data : FILL;
          under_nx = ~hold_valid;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_s2[ch_idx]) begin
          state_nx = IDLE;
        end else if (other_low) begin
          state_nx = CONFLICT;
        end else if (sclk_rise) begin
          if (bit_cnt < CW'(WIDTH)) begin
            cnt_nx  = bit_cnt + 1'b1;
            done_nx = (cnt_nx == CW'(WIDTH));
          end
        end else if (sclk_fall) begin
          // The falling edge after the last bit starts the next word under the same select.
          if (bit_cnt == CW'(WIDTH)) begin
            take     = 1'b1;
            sh_nx    = hold_valid ? hold_data : FILL;
            under_nx = ~hold_valid;
            cnt_nx   = '0;
          end else begin
            sh_nx = {shreg[WIDTH-2:0], 1'b0};
          end
        end
      end
      CONFLICT: begin
        if (&ss_s2) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch_idx    <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nx;
      ch_idx    <= ch_nx;
      shreg     <= sh_nx;
      bit_cnt   <= cnt_nx;
      word_done <= done_nx;
      underrun  <= under_nx;
    end
  end

  // A reload drains the holding register; a load is only taken while it is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (tx_valid && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_data  <= tx_data;
    end else if (take) begin
      hold_valid <= 1'b0;
    end
  end

  assign tx_ready = ~hold_valid;
  assign conflict = (state == CONFLICT);
  assign miso_oe  = (state == SHIFT) ? sel_mask : '0;
  assign miso_d   = (state == SHIFT && shreg[WIDTH-1]) ? sel_mask : '0;

`ifdef MISO_READBACK_CHECK_EN
  logic probe;

  always_ff @(posedge clk) begin
    if (rst) begin
      probe <= 1'b0;
    end else if (state == SHIFT && sclk_rise && (miso_in != shreg[WIDTH-1])) begin
      probe <= 1'b1;
    end
  end

  assign miso_probe = probe;
`else
  logic unused_miso_in;
  assign unused_miso_in = miso_in;
  assign miso_probe     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_miso_tri_ctrl.sv
// Self-checking bench for spi_miso_tri_ctrl: an SPI mode-0 master drives random frames and a
// word-level model (queue of loaded words, FILL on empty) predicts every sampled MISO bit.
module tb_spi_miso_tri_ctrl;

  localparam int               NUM_CH    = 4;
  localparam int               WIDTH     = 8;
  localparam logic [WIDTH-1:0] FILL_WORD = 8'h00;
  localparam int               HALF      = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ss_n;
  logic              sclk;
  logic [WIDTH-1:0]  tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [NUM_CH-1:0] miso_d;
  logic [NUM_CH-1:0] miso_oe;
  logic              word_done;
  logic              underrun;
  logic              conflict;
  logic              miso_in;
  logic              miso_probe;

  int checks   = 0;
  int errors   = 0;
  int expDone  = 0;
  int gotDone  = 0;
  int expUnder = 0;
  int gotUnder = 0;
  bit expProbe  = 1'b0;
  bit forceZero = 1'b0;
  logic [WIDTH-1:0] pending[$];

  spi_miso_tri_ctrl #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .FILL(FILL_WORD)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .sclk(sclk),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .miso_d(miso_d), .miso_oe(miso_oe), .word_done(word_done),
    .underrun(underrun), .conflict(conflict),
    .miso_in(miso_in), .miso_probe(miso_probe)
  );

  // Pad loopback: the readback sees the driven level unless the bench forces the pad low.
  assign miso_in = forceZero ? 1'b0 : |(miso_d & miso_oe);

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (word_done) gotDone++;
      if (underrun) gotUnder++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    waitClk(3);
    rst = 1'b0;
    waitClk(1);
    pending.delete();
    expProbe = 1'b0;
  endtask

  task automatic loadWord(input logic [WIDTH-1:0] w);
    int n = 0;
    while (!tx_ready && n < 50) begin
      waitClk(1);
      n++;
    end
    checkOutput("load_ready", tx_ready, 1);
    tx_data  = w;
    tx_valid = 1'b1;
    waitClk(1);
    tx_valid = 1'b0;
    pending.push_back(w);
    checkOutput("load_taken", tx_ready, 0);
  endtask

  task automatic nextWord(output logic [WIDTH-1:0] w);
    if (pending.size() > 0) begin
      w = pending.pop_front();
    end else begin
      w = FILL_WORD;
      expUnder++;
    end
  endtask

  function automatic logic [NUM_CH-1:0] onehot(input int ch, input logic v);
    logic [NUM_CH-1:0] m;
    m = '0;
    m[ch] = v;
    return m;
  endfunction

  task automatic shiftBits(input int ch, input int nBits, input bit chain,
                           input logic [WIDTH-1:0] cw, inout logic [WIDTH-1:0] cur);
    for (int b = 0; b < nBits; b++) begin
      int k = b % WIDTH;
      checkOutput("miso_d", miso_d, onehot(ch, cur[WIDTH-1-k]));
      checkOutput("oe_bit", miso_oe, onehot(ch, 1'b1));
      if (chain && k == 2 && pending.size() == 0) loadWord(cw);
      sclk = 1'b1;
      waitClk(HALF);
`ifdef MISO_READBACK_CHECK_EN
      if (forceZero && cur[WIDTH-1-k]) expProbe = 1'b1;
`endif
      if (forceZero) checkOutput("probe_rise", miso_probe, expProbe);
      if (k == WIDTH - 1) expDone++;
      sclk = 1'b0;
      waitClk(HALF);
      if (k == WIDTH - 1) begin
        nextWord(cur);
        checkOutput("tx_ready_reload", tx_ready, 1);
      end
    end
  endtask

  // One select frame of nBits SPI clocks; ends with release and counter/flag checks.
  task automatic applyStimulus(input int ch, input int nBits, input bit preload,
                               input logic [WIDTH-1:0] pw, input bit chain,
                               input logic [WIDTH-1:0] cw);
    logic [WIDTH-1:0] cur;
    if (preload && pending.size() == 0) loadWord(pw);
    waitClk(2);
    ss_n[ch] = 1'b0;
    waitClk(HALF);
    checkOutput("oe_select", miso_oe, onehot(ch, 1'b1));
    checkOutput("tx_ready_sel", tx_ready, 1);
    nextWord(cur);
    shiftBits(ch, nBits, chain, cw, cur);
    ss_n[ch] = 1'b1;
    waitClk(HALF);
    checkOutput("oe_release", miso_oe, 0);
    checkOutput("d_release", miso_d, 0);
    checkOutput("done_count", gotDone, expDone);
    checkOutput("under_count", gotUnder, expUnder);
    checkOutput("probe", miso_probe, expProbe);
    checkOutput("tx_ready_idle", tx_ready, (pending.size() == 0) ? 1 : 0);
  endtask

  task automatic applyConflict(input int a, input int b, input int nBits);
    logic [WIDTH-1:0] cur;
    if (pending.size() == 0) loadWord(8'($urandom));
    waitClk(2);
    ss_n[a] = 1'b0;
    waitClk(HALF);
    nextWord(cur);
    shiftBits(a, nBits, 1'b0, 8'h00, cur);
    ss_n[b] = 1'b0;
    waitClk(HALF);
    checkOutput("conflict_set", conflict, 1);
    checkOutput("conflict_oe", miso_oe, 0);
    checkOutput("conflict_d", miso_d, 0);
    ss_n[a] = 1'b1;
    ss_n[b] = 1'b1;
    waitClk(HALF);
    checkOutput("conflict_clr", conflict, 0);
    checkOutput("conflict_done", gotDone, expDone);
    checkOutput("conflict_under", gotUnder, expUnder);
  endtask

  initial begin
    ss_n     = '1;
    sclk     = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    doReset();

    checkOutput("rst_oe", miso_oe, 0);
    checkOutput("rst_d", miso_d, 0);
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_done", word_done, 0);
    checkOutput("rst_under", underrun, 0);
    checkOutput("rst_conflict", conflict, 0);
    checkOutput("rst_probe", miso_probe, 0);

    applyStimulus(2, 8, 1'b1, 8'hA5, 1'b0, 8'h00);
    applyStimulus(0, 8, 1'b0, 8'h00, 1'b0, 8'h00);
    applyConflict(1, 3, 4);
    applyStimulus(1, 4, 1'b1, 8'h3C, 1'b0, 8'h00);
    applyStimulus(1, 8, 1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(3, 16, 1'b1, 8'h81, 1'b1, 8'h7E);

    for (int i = 0; i < 16; i++) begin
      int ch = $urandom_range(0, NUM_CH - 1);
      int r  = $urandom_range(0, 3);
      if (r == 0) begin
        applyStimulus(ch, 8, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
      end else if (r == 1) begin
        applyStimulus(ch, 16, 1'($urandom), 8'($urandom), 1'b1, 8'($urandom));
      end else if (r == 2) begin
        applyStimulus(ch, $urandom_range(1, 7), 1'($urandom), 8'($urandom),
                      1'($urandom), 8'($urandom));
      end else begin
        int other = (ch + $urandom_range(1, NUM_CH - 1)) % NUM_CH;
        applyConflict(ch, other, $urandom_range(1, 6));
      end
    end

    forceZero = 1'b1;
    applyStimulus(0, 8, 1'b1, 8'hFF, 1'b0, 8'h00);
    forceZero = 1'b0;
    applyStimulus(2, 8, 1'b1, 8'h5A, 1'b0, 8'h00);
    doReset();
    checkOutput("probe_after_rst", miso_probe, 0);
    checkOutput("tx_ready_after_rst", tx_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_miso_tri_ctrl.md
Name: spi_miso_tri_ctrl

Overview:
- Parametrised successor to the single-channel MISO tristate stage: drives MISO for NUM_CH slave-select channels from one shared transmit shifter.
- Output-enable goes only to the one selected channel. Multiple selects are detected as a conflict and all channels are tristated.
- Optionally checks the pad readback (miso_in) against the driven bit.
- Sits between the SPI-slave datapath and the top-level TRIBUFF_LVCMOS33 pads. The pads take miso_d/miso_oe, so there is no inverter in the path.

Parameters:
- NUM_CH, 4, number of slave-select/MISO channels (1..16).
- WIDTH, 8, bits per SPI word (2..32).
- FILL, 0, word shifted out when no tx word is buffered at select (WIDTH bits, zero-extended).

Ports:
- clk  input  1  system clock; sclk/ss_n are oversampled in this domain.
- rst  input  1  synchronous active-high reset.
- ss_n  input  NUM_CH  active-low slave selects, asynchronous.
- sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous.
- tx_data  input  WIDTH  next word to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding register empty.
- miso_d  output  NUM_CH  per-channel pad data (TRIBUFF D).
- miso_oe  output  NUM_CH  per-channel pad enable (TRIBUFF E), one-hot or zero.
- word_done  output  1  one-cycle pulse, full word shifted.
- underrun  output  1  one-cycle pulse, FILL used.
- conflict  output  1  level, more than one synchronized ss_n low.
- miso_in  input  1  pad readback of the active channel.
- miso_probe  output  1  sticky readback mismatch flag.

Behaviour:
- Reset: everything is synchronous on rst.
  - Outputs: miso_oe=0, miso_d=0, tx_ready=1, word_done=0, underrun=0, conflict=0, miso_probe=0.
  - Internal: holding register empty, state IDLE, bit_cnt=0.
- Synchronizers: ss_n and sclk each pass through a 2-flop synchronizer. Edge detect compares sync stage 2 against a third flop.
- Holding register: tx_valid&&tx_ready loads tx_data and tx_ready drops next cycle. The register empties (tx_ready=1 next cycle) when a word moves to the shifter.
- FSM states: IDLE, SHIFT, CONFLICT.
- IDLE:
  - Exactly one synced ss_n low: latch ch_idx and load the shifter from the holding register (or FILL with an underrun pulse). Assert miso_oe[ch_idx] next cycle, present the MSB on miso_d[ch_idx], bit_cnt=0, go to SHIFT.
  - More than one synced ss_n low: go to CONFLICT.
- SHIFT:
  - sclk rising: bit_cnt++.
  - sclk falling with bit_cnt<WIDTH: shift and present the next bit.
  - bit_cnt reaches WIDTH on a rising edge: pulse word_done. The next falling edge reloads the shifter (holding or FILL, with the same rules as IDLE) and resets bit_cnt, so back-to-back words continue without an ss_n gap.
  - ss_n[ch_idx] deasserts: abort. miso_oe goes to 0 next cycle, the partial word is discarded, no word_done, go to IDLE.
  - Any other ss_n goes low: go to CONFLICT.
- CONFLICT:
  - conflict=1 and miso_oe=0 on all channels.
  - Exit to IDLE only when all synced ss_n are high. conflict drops in the same cycle.
- Non-selected channels always have miso_d=0 and miso_oe=0.
- Latency: ss_n fall to miso_oe is 3 clk cycles. sclk fall to miso_d change is 3 clk cycles. clk must be ≥8× sclk.
- Simultaneous tx_valid load and shifter reload: the reload takes the old holding word, and the new word is accepted only if the holding register was empty before the reload. Defined rule: the shifter takes priority and the load waits (tx_ready low).

Optional Feature:
- Macro: MISO_READBACK_CHECK_EN.
- Defined: on each sclk rising edge in SHIFT, miso_in is compared with the currently driven bit. A mismatch sets miso_probe, which stays sticky until rst.
- Undefined: miso_in is ignored and miso_probe is tied 0.

Test Plan:
1. NUM_CH=4, WIDTH=8; load 0xA5, drop ss_n[2], 8 sclk → miso_d[2] sequence 1,0,1,0,0,1,0,1; miso_oe=4'b0100; one word_done pulse; tx_ready=1 after select.
2. No word loaded; select ch0, 8 sclk → FILL (0x00) shifted, one underrun pulse, word_done pulse.
3. ss_n[1] low, then ss_n[3] low mid-word → conflict=1, miso_oe=0 on all channels; release both → conflict=0, IDLE, no word_done.
4. Load 0x3C, select ch1, 4 sclk, deassert ss_n[1] → miso_oe[1]=0 next cycle, no word_done; reselect → FILL with underrun (word consumed).
5. Back-to-back 0x81 then 0x7E under one ss_n, 16 sclk → contiguous bits, two word_done pulses, tx_ready reasserted after each reload.
6. MISO_READBACK_CHECK_EN defined; force miso_in=0 while driving 0xFF → miso_probe=1 after first sclk rise and held until rst; undefined → miso_probe stays 0.
